// File: rtl/bp_pkg.sv
// Shared helpers for the branch target predictor: counter encodings and PC field extraction.
// Entry layout itself lives in the top because its widths follow the instance parameters.
package bp_pkg;

    function automatic logic [31:0] weak_taken(input int ctr_bits);
        return 32'(1) << (ctr_bits - 1);
    endfunction

    function automatic logic [31:0] weak_not_taken(input int ctr_bits);
        return weak_taken(ctr_bits) - 32'd1;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int ctr_bits);
        logic [31:0] max_v;
        max_v = (32'(1) << ctr_bits) - 32'd1;
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

    function automatic logic [31:0] sat_dec(input logic [31:0] v);
        return (v == 32'd0) ? 32'd0 : v - 32'd1;
    endfunction

    // 64-bit mask so TAG_BITS up to 32 does not overflow the shift
    function automatic logic [31:0] tag_of(input logic [31:0] pc, input int entry_bits,
                                           input int tag_bits);
        logic [63:0] mask;
        mask = (64'(1) << tag_bits) - 64'd1;
        return 32'((64'(pc) >> (entry_bits + 2)) & mask);
    endfunction

    function automatic logic [31:0] idx_of(input logic [31:0] pc, input int entry_bits);
        return (pc >> 2) & ((32'(1) << entry_bits) - 32'd1);
    endfunction

endpackage

// File: rtl/bp_stat_counter.sv
// Saturating up-counter with synchronous clear, used for branch/mispredict statistics.
module bp_stat_counter #(
    parameter int STAT_BITS = 16
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic                 inc,
    output logic [STAT_BITS-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear)
            count <= '0;
        else if (inc && count != '1)
            count <= count + STAT_BITS'(1);
    end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped tagged BTB with saturating direction counters; combinational fetch lookup,
// synchronous execute training. Define BTP_GSHARE_EN to XOR global history into the index.
module branch_target_predictor
    import bp_pkg::*;
#(
    parameter int ENTRY_BITS = 4,
    parameter int TAG_BITS   = 8,
    parameter int CTR_BITS   = 2,
    parameter int STAT_BITS  = 16
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic [31:0]           PC_F,
    output logic                  PrPCSrc_F,
    output logic [31:0]           PrALUResult_F,
    output logic [ENTRY_BITS-1:0] PrIndex_F,
    input  logic                  Update_E,
    input  logic [ENTRY_BITS-1:0] Index_E,
    input  logic [31:0]           PC_E,
    input  logic                  PCSrc_E,
    input  logic [31:0]           ALUResult_E,
    input  logic                  Mispredict_E,
    output logic [STAT_BITS-1:0]  BrCount,
    output logic [STAT_BITS-1:0]  MispCount
);

    localparam int ENTRIES = 1 << ENTRY_BITS;

    typedef struct packed {
        logic                valid;
        logic [TAG_BITS-1:0] tag;
        logic [31:0]         target;
        logic [CTR_BITS-1:0] ctr;
    } entry_t;

    logic [ENTRIES-1:0]  valid_q;
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

    logic [ENTRY_BITS-1:0] idx;
    entry_t                rd;
    entry_t                ue;
    logic                  hit;
    logic                  upd_hit;
    logic [TAG_BITS-1:0]   tag_f;
    logic [TAG_BITS-1:0]   tag_e;

`ifdef BTP_GSHARE_EN
    logic [ENTRY_BITS-1:0] ghr;

    always_ff @(posedge CLK) begin
        if (!Reset)
            ghr <= '0;
        else if (Update_E)
            ghr <= ENTRY_BITS'({ghr, PCSrc_E});
    end

    assign idx = ENTRY_BITS'(idx_of(PC_F, ENTRY_BITS)) ^ ghr;
`else
    assign idx = ENTRY_BITS'(idx_of(PC_F, ENTRY_BITS));
`endif

    assign tag_f = TAG_BITS'(tag_of(PC_F, ENTRY_BITS, TAG_BITS));
    assign tag_e = TAG_BITS'(tag_of(PC_E, ENTRY_BITS, TAG_BITS));

    always_comb begin
        rd = '{valid: valid_q[idx], tag: tag_q[idx], target: target_q[idx], ctr: ctr_q[idx]};
        ue = '{valid: valid_q[Index_E], tag: tag_q[Index_E], target: target_q[Index_E],
               ctr: ctr_q[Index_E]};
    end

    assign hit     = rd.valid && (rd.tag == tag_f);
    assign upd_hit = ue.valid && (ue.tag == tag_e);

    // Prediction is suppressed while reset is held so fetch falls through sequentially
    assign PrPCSrc_F     = Reset && hit && rd.ctr[CTR_BITS-1];
    assign PrALUResult_F = PrPCSrc_F ? rd.target : PC_F + 32'd4;
    assign PrIndex_F     = idx;

    // Tag and target arrays are left untouched by reset; valid gates their use
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++)
                ctr_q[i] <= CTR_BITS'(weak_not_taken(CTR_BITS));
        end else if (Update_E) begin
            if (upd_hit) begin
                if (PCSrc_E) begin
                    ctr_q[Index_E]    <= CTR_BITS'(sat_inc(32'(ue.ctr), CTR_BITS));
                    target_q[Index_E] <= ALUResult_E;
                end else begin
                    ctr_q[Index_E]    <= CTR_BITS'(sat_dec(32'(ue.ctr)));
                end
            end else if (PCSrc_E) begin
                valid_q[Index_E]  <= 1'b1;
                tag_q[Index_E]    <= tag_e;
                target_q[Index_E] <= ALUResult_E;
                ctr_q[Index_E]    <= CTR_BITS'(weak_taken(CTR_BITS));
            end
        end
    end

    bp_stat_counter #(.STAT_BITS(STAT_BITS)) u_br_cnt (
        .clk   (CLK),
        .clear (!Reset),
        .inc   (Update_E),
        .count (BrCount)
    );

    bp_stat_counter #(.STAT_BITS(STAT_BITS)) u_misp_cnt (
        .clk   (CLK),
        .clear (!Reset),
        .inc   (Update_E && Mispredict_E),
        .count (MispCount)
    );

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench: a default instance plus a STAT_BITS=4 instance sharing the same stimulus.
module tb_branch_target_predictor;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [31:0] PC_F;
    logic        Update_E;
    logic [3:0]  Index_E;
    logic [31:0] PC_E;
    logic        PCSrc_E;
    logic [31:0] ALUResult_E;
    logic        Mispredict_E;

    logic        PrPCSrc_F;
    logic [31:0] PrALUResult_F;
    logic [3:0]  PrIndex_F;
    logic [15:0] BrCount;
    logic [15:0] MispCount;

    logic        PrPCSrc_F4;
    logic [31:0] PrALUResult_F4;
    logic [3:0]  PrIndex_F4;
    logic [3:0]  BrCount4;
    logic [3:0]  MispCount4;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    branch_target_predictor u_dut (
        .CLK(CLK), .Reset(Reset), .PC_F(PC_F),
        .PrPCSrc_F(PrPCSrc_F), .PrALUResult_F(PrALUResult_F), .PrIndex_F(PrIndex_F),
        .Update_E(Update_E), .Index_E(Index_E), .PC_E(PC_E), .PCSrc_E(PCSrc_E),
        .ALUResult_E(ALUResult_E), .Mispredict_E(Mispredict_E),
        .BrCount(BrCount), .MispCount(MispCount)
    );

    branch_target_predictor #(.STAT_BITS(4)) u_dut4 (
        .CLK(CLK), .Reset(Reset), .PC_F(PC_F),
        .PrPCSrc_F(PrPCSrc_F4), .PrALUResult_F(PrALUResult_F4), .PrIndex_F(PrIndex_F4),
        .Update_E(Update_E), .Index_E(Index_E), .PC_E(PC_E), .PCSrc_E(PCSrc_E),
        .ALUResult_E(ALUResult_E), .Mispredict_E(Mispredict_E),
        .BrCount(BrCount4), .MispCount(MispCount4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drive one update for a single edge, then drop Update_E
    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                       input logic misp);
        Update_E     = 1'b1;
        PC_E         = pc;
        Index_E      = pc[5:2];
        PCSrc_E      = tk;
        ALUResult_E  = tgt;
        Mispredict_E = misp;
        tick();
        Update_E     = 1'b0;
        Mispredict_E = 1'b0;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic tk,
                        input logic [31:0] nxt);
        PC_F = pc;
        #1;
        chk({tag, "_taken"}, 32'(PrPCSrc_F), 32'(tk));
        chk({tag, "_next"}, PrALUResult_F, nxt);
    endtask

    initial begin
        Reset = 1'b0; PC_F = 32'h40; Update_E = 1'b0; Index_E = '0; PC_E = '0;
        PCSrc_E = 1'b0; ALUResult_E = '0; Mispredict_E = 1'b0;
        #1;
        chk("in_reset_taken", 32'(PrPCSrc_F), 32'd0);
        chk("in_reset_next", PrALUResult_F, 32'h44);
        tick();
        Reset = 1'b1;

        look("post_reset", 32'h40, 1'b0, 32'h44);
        chk("post_reset_idx", 32'(PrIndex_F), 32'd0);
        chk("post_reset_br", 32'(BrCount), 32'd0);
        chk("post_reset_misp", 32'(MispCount), 32'd0);

        upd(32'h40, 1'b1, 32'h100, 1'b1);          // allocate, ctr=2
        look("alloc", 32'h40, 1'b1, 32'h100);

        look("alias_miss", 32'h440, 1'b0, 32'h444);
        chk("alias_idx", 32'(PrIndex_F), 32'd0);
        upd(32'h440, 1'b0, 32'h0, 1'b0);           // miss, not taken: no change
        look("alias_keep", 32'h40, 1'b1, 32'h100);

        upd(32'h40, 1'b0, 32'h0, 1'b1);            // ctr 1
        look("nt1", 32'h40, 1'b0, 32'h44);
        upd(32'h40, 1'b0, 32'h0, 1'b0);            // ctr 0
        upd(32'h40, 1'b0, 32'h0, 1'b0);            // ctr stays 0
        upd(32'h40, 1'b1, 32'h200, 1'b1);          // ctr 1
        look("t1_from_floor", 32'h40, 1'b0, 32'h44);
        upd(32'h40, 1'b1, 32'h200, 1'b1);          // ctr 2
        look("t2", 32'h40, 1'b1, 32'h200);
        upd(32'h40, 1'b1, 32'h200, 1'b0);          // ctr 3
        upd(32'h40, 1'b1, 32'h200, 1'b0);          // ctr stays 3
        look("t_sat", 32'h40, 1'b1, 32'h200);
        upd(32'h40, 1'b0, 32'h0, 1'b1);            // ctr 2
        look("sat_nt1", 32'h40, 1'b1, 32'h200);
        upd(32'h40, 1'b0, 32'h0, 1'b0);            // ctr 1
        look("sat_nt2", 32'h40, 1'b0, 32'h44);
        chk("br_11", 32'(BrCount), 32'd11);
        chk("misp_5", 32'(MispCount), 32'd5);

        // Same-cycle lookup and update: old contents before the edge, new after
        PC_F = 32'h40;
        Update_E = 1'b1; PC_E = 32'h40; Index_E = 4'd0; PCSrc_E = 1'b1;
        ALUResult_E = 32'h300; Mispredict_E = 1'b0;
        #1;
        chk("same_cyc_old", PrALUResult_F, 32'h44);
        tick();
        Update_E = 1'b0;
        look("same_cyc_new", 32'h40, 1'b1, 32'h300);
        Update_E = 1'b1; ALUResult_E = 32'h380;
        #1;
        chk("same_cyc_old_tgt", PrALUResult_F, 32'h300);
        tick();
        Update_E = 1'b0;
        look("same_cyc_new_tgt", 32'h40, 1'b1, 32'h380);

        look("idx2_miss", 32'h48, 1'b0, 32'h4C);
        chk("idx2_idx", 32'(PrIndex_F), 32'd2);
        upd(32'h48, 1'b1, 32'h500, 1'b0);
        look("idx2_hit", 32'h48, 1'b1, 32'h500);
        look("idx0_intact", 32'h40, 1'b1, 32'h380);

        look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);
        chk("wrap_idx", 32'(PrIndex_F), 32'd15);
        chk("br_14", 32'(BrCount), 32'd14);

        // Reset mid-stream with an update pending: update must be discarded
        PC_F = 32'h40;
        Reset = 1'b0;
        Update_E = 1'b1; PC_E = 32'h40; Index_E = 4'd0; PCSrc_E = 1'b1;
        ALUResult_E = 32'h600; Mispredict_E = 1'b1;
        #1;
        chk("rst_force_taken", 32'(PrPCSrc_F), 32'd0);
        chk("rst_force_next", PrALUResult_F, 32'h44);
        tick();
        Reset = 1'b1; Update_E = 1'b0; Mispredict_E = 1'b0;
        look("rst_miss0", 32'h40, 1'b0, 32'h44);
        look("rst_miss2", 32'h48, 1'b0, 32'h4C);
        chk("rst_br", 32'(BrCount), 32'd0);
        chk("rst_misp", 32'(MispCount), 32'd0);
        chk("rst_br4", 32'(BrCount4), 32'd0);

        for (int i = 0; i < 20; i++)
            upd(32'h80, 1'b0, 32'h0, 1'b1);
        chk("br_20", 32'(BrCount), 32'd20);
        chk("misp_20", 32'(MispCount), 32'd20);
        chk("br4_sat", 32'(BrCount4), 32'd15);
        chk("misp4_sat", 32'(MispCount4), 32'd15);
        look("nt_miss_no_alloc", 32'h80, 1'b0, 32'h84);

        upd(32'h80, 1'b1, 32'h700, 1'b0);
        look("post_rst_alloc", 32'h80, 1'b1, 32'h700);
        look("post_rst_alloc4", 32'h80, PrPCSrc_F4, PrALUResult_F4);
        chk("br_21", 32'(BrCount), 32'd21);
        chk("br4_hold", 32'(BrCount4), 32'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
